// File: rtl/systemizer_multipass_ctrl_if.sv
// Host and phase-engine signal bundle for the multipass systemizer controller.
// cycle_count is present only when SYSTEMIZER_CYCLE_COUNT_EN is defined.
interface systemizer_multipass_ctrl_if #(
    parameter int BW = 5
);
    logic          start;
    logic          start_right;
    logic          abort;
    logic          retry_ack;
    logic          phase_done;
    logic          phase_fail;
    logic          start_phase;
    logic [BW-1:0] start_block;
    logic          last_phase;
    logic          init_left;
    logic          init_right;
    logic [1:0]    gen_left_op;
    logic [1:0]    gen_right_op;
    logic          retry_req;
    logic          busy;
    logic          done;
    logic          success;
    logic          fail;
    logic [BW-1:0] fail_block;
    logic [3:0]    retry_cnt;
`ifdef SYSTEMIZER_CYCLE_COUNT_EN
    logic [31:0]   cycle_count;
`endif

    modport master (
        input  start, start_right, abort, retry_ack, phase_done, phase_fail,
`ifdef SYSTEMIZER_CYCLE_COUNT_EN
        output cycle_count,
`endif
        output start_phase, start_block, last_phase, init_left, init_right,
        output gen_left_op, gen_right_op, retry_req, busy, done, success,
        output fail, fail_block, retry_cnt
    );

    modport slave (
        output start, start_right, abort, retry_ack, phase_done, phase_fail,
`ifdef SYSTEMIZER_CYCLE_COUNT_EN
        input  cycle_count,
`endif
        input  start_phase, start_block, last_phase, init_left, init_right,
        input  gen_left_op, gen_right_op, retry_req, busy, done, success,
        input  fail, fail_block, retry_cnt
    );
endinterface

// File: rtl/systemizer_multipass_ctrl.sv
// Multipass systemizer sequencer: left pass, optional right pass, bounded retry, abort; SYSTEMIZER_CYCLE_COUNT_EN adds cycle_count.
// Latency: start_phase 1 cycle after start/retry_ack/pass hand-off, 2 cycles after phase_done within a pass.
// No backpressure: host and engine pulses arriving outside their accepting state are dropped.
module systemizer_multipass_ctrl #(
    parameter int N          = 20,
    parameter int L          = 200,
    parameter int K          = 400,
    parameter int RIGHT_PASS = 1,
    parameter int MAX_RETRY  = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    systemizer_multipass_ctrl_if.master bus
);
    localparam int PL        = (L + N - 1) / N;
    localparam int KB        = (K + N - 1) / N;
    localparam int BW        = $clog2(KB + 1);
    localparam bit LP_LEFT   = (L % N) != 0;
    localparam bit LP_RIGHT  = (K % N) != 0;
    localparam bit HAS_RIGHT = KB > PL;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RETRY, FINISH} state_t;

    state_t        state_q, state_d;
    logic          sp_q, sp_d;
    logic          il_q, il_d;
    logic          ir_q, ir_d;
    logic          right_q, right_d;
    logic          fail_q, fail_d;
    logic [BW-1:0] blk_q, blk_d;
    logic [BW-1:0] fblk_q, fblk_d;
    logic [3:0]    retry_q, retry_d;
    logic          busy_w;

    assign busy_w = (state_q == LAUNCH) || (state_q == WAIT) || (state_q == RETRY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sp_q    <= 1'b0;
            il_q    <= 1'b0;
            ir_q    <= 1'b0;
            right_q <= 1'b0;
            fail_q  <= 1'b0;
            blk_q   <= '0;
            fblk_q  <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            il_q    <= il_d;
            ir_q    <= ir_d;
            right_q <= right_d;
            fail_q  <= fail_d;
            blk_q   <= blk_d;
            fblk_q  <= fblk_d;
            retry_q <= retry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sp_d    = 1'b0;
        il_d    = 1'b0;
        ir_d    = 1'b0;
        right_d = right_q;
        fail_d  = fail_q;
        blk_d   = blk_q;
        fblk_d  = fblk_q;
        retry_d = retry_q;
        // Abort outranks every engine/host event once a run is in flight.
        if (bus.abort && busy_w) begin
            fail_d  = 1'b1;
            fblk_d  = blk_q;
            state_d = FINISH;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = WAIT;
                        sp_d    = 1'b1;
                        il_d    = 1'b1;
                        blk_d   = '0;
                        right_d = 1'b0;
                        fail_d  = 1'b0;
                        fblk_d  = '0;
                        retry_d = '0;
                    end else if (bus.start_right) begin
                        right_d = 1'b1;
                        fail_d  = 1'b0;
                        retry_d = '0;
                        if (HAS_RIGHT) begin
                            state_d = WAIT;
                            sp_d    = 1'b1;
                            ir_d    = 1'b1;
                            blk_d   = BW'(PL);
                        end else begin
                            state_d = FINISH;
                        end
                    end
                end
                LAUNCH: begin
                    state_d = WAIT;
                    sp_d    = 1'b1;
                    blk_d   = blk_q + BW'(1);
                end
                WAIT: begin
                    if (bus.phase_fail) begin
                        fblk_d = blk_q;
                        if (!right_q && (retry_q < 4'(MAX_RETRY))) begin
                            retry_d = retry_q + 4'd1;
                            state_d = RETRY;
                        end else begin
                            fail_d  = 1'b1;
                            state_d = FINISH;
                        end
                    end else if (bus.phase_done) begin
                        if (!right_q && (blk_q == BW'(PL - 1))) begin
                            if ((RIGHT_PASS != 0) && HAS_RIGHT) begin
                                state_d = WAIT;
                                sp_d    = 1'b1;
                                ir_d    = 1'b1;
                                right_d = 1'b1;
                                blk_d   = BW'(PL);
                            end else begin
                                state_d = FINISH;
                            end
                        end else if (right_q && (blk_q == BW'(KB - 1))) begin
                            state_d = FINISH;
                        end else begin
                            state_d = LAUNCH;
                        end
                    end
                end
                RETRY: begin
                    if (bus.retry_ack) begin
                        state_d = WAIT;
                        sp_d    = 1'b1;
                        il_d    = 1'b1;
                        right_d = 1'b0;
                        blk_d   = '0;
                    end
                end
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.start_phase  = sp_q;
    assign bus.start_block  = blk_q;
    assign bus.init_left    = il_q;
    assign bus.init_right   = ir_q;
    assign bus.last_phase   = (state_q == WAIT) &&
                              (right_q ? (LP_RIGHT && (blk_q == BW'(KB - 1)))
                                       : (LP_LEFT  && (blk_q == BW'(PL - 1))));
    assign bus.gen_left_op  = 2'b01;
    assign bus.gen_right_op = (RIGHT_PASS != 0) ? 2'b01 : 2'b00;
    assign bus.retry_req    = (state_q == RETRY);
    assign bus.busy         = busy_w;
    assign bus.done         = (state_q == FINISH);
    assign bus.success      = (state_q == FINISH) && !fail_q;
    assign bus.fail         = fail_q;
    assign bus.fail_block   = fblk_q;
    assign bus.retry_cnt    = retry_q;

`ifdef SYSTEMIZER_CYCLE_COUNT_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
        end else if ((state_q == IDLE) && (bus.start || bus.start_right)) begin
            cyc_q <= '0;
        end else if (busy_w && (cyc_q != 32'hFFFF_FFFF)) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign bus.cycle_count = cyc_q;
`endif
endmodule
